// File: rtl/day33_100bit_adder_if.sv
// Operand/result bundle for the registered carry-select adder.
// The master drives operands and observes results; the adder is the slave.
interface day33_100bit_adder_if #(
  parameter int unsigned WIDTH = 100
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             out_valid;

  modport master (
    output in_valid,
    output A,
    output B,
    output Cin,
    input  Sum,
    input  Cout,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  Cin,
    output Sum,
    output Cout,
    output out_valid
  );
endinterface

// File: rtl/day33_100bit_adder.sv
// Registered WIDTH-bit adder: {Cout, Sum} = A + B + Cin, one cycle latency.
// Carry-select datapath built from BLOCK-bit ripple slices of full-adder cells.
module day33_100bit_adder #(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned BLOCK = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  day33_100bit_adder_if.slave   bus
);

  localparam int unsigned NSLICE = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0) begin : g_bad_block
    $error("day33_100bit_adder: WIDTH must be a multiple of BLOCK");
  end

  // BLOCK-bit ripple chain of full-adder cells; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             ci
  );
    logic             c;
    logic [BLOCK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [NSLICE:0]  carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = bus.Cin;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    logic [BLOCK-1:0] a_s;
    logic [BLOCK-1:0] b_s;

    assign a_s = bus.A[k*BLOCK +: BLOCK];
    assign b_s = bus.B[k*BLOCK +: BLOCK];

    if (k == 0) begin : g_first
      logic [BLOCK:0] r;
      assign r                    = ripple(a_s, b_s, carry[0]);
      assign sum_c[0 +: BLOCK]    = r[BLOCK-1:0];
      assign carry[1]             = r[BLOCK];
    end else begin : g_select
      // Both carry hypotheses are precomputed; the incoming carry only steers the mux.
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      logic [BLOCK:0] r_sel;
      assign r0                      = ripple(a_s, b_s, 1'b0);
      assign r1                      = ripple(a_s, b_s, 1'b1);
      assign r_sel                   = carry[k] ? r1 : r0;
      assign sum_c[k*BLOCK +: BLOCK] = r_sel[BLOCK-1:0];
      assign carry[k+1]              = r_sel[BLOCK];
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  // Result register; operands are ignored unless in_valid, so idle inputs never disturb Sum/Cout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_c;
        cout_q <= carry[NSLICE];
      end
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_day33_100bit_adder.sv
// Directed and random checks for the registered 100-bit carry-select adder.
module tb_day33_100bit_adder;

  localparam int unsigned W   = 100;
  localparam int unsigned BLK = 10;
  localparam int unsigned NS  = W / BLK;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [W-1:0] ones;
  logic [W-1:0] one;
  logic [W-1:0] a_v;
  logic [W-1:0] b_v;
  logic         c_v;
  logic [W:0]   exp_v;
  logic [127:0] rnd;

  day33_100bit_adder_if #(.WIDTH(W)) bus ();

  day33_100bit_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec, input logic ev);
    check({tag, ".sum"},   {1'b0, bus.Sum},            {1'b0, es});
    check({tag, ".cout"},  (W+1)'(bus.Cout),           (W+1)'(ec));
    check({tag, ".valid"}, (W+1)'(bus.out_valid),      (W+1)'(ev));
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return W'(r);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    ones   = '1;
    one    = W'(1);
    rst_n  = 1'b0;
    drive(1'b1, rand_word(), rand_word(), 1'b1);

    // Reset held two clocks with live operands
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_word(), rand_word(), 1'(i));
      tick();
      check_result($sformatf("reset%0d", i), '0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // Full-length propagate chain
    drive(1'b1, ones, '0, 1'b1);
    tick();
    check_result("max_chain", '0, 1'b1, 1'b1);

    drive(1'b1, ones, ones, 1'b1);
    tick();
    check_result("ovf_cin1", ones, 1'b1, 1'b1);

    drive(1'b1, ones, ones, 1'b0);
    tick();
    check_result("ovf_cin0", {ones[W-1:1], 1'b0}, 1'b1, 1'b1);

    // Hold with new operands and in_valid low
    drive(1'b0, W'(123), W'(456), 1'b1);
    tick();
    check_result("hold0", {ones[W-1:1], 1'b0}, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check_result("hold1", {ones[W-1:1], 1'b0}, 1'b1, 1'b0);

    drive(1'b1, '0, '0, 1'b0);
    tick();
    check_result("zero", '0, 1'b0, 1'b1);

    // Carry crossing each slice boundary, via B and via Cin
    for (int k = 1; k < int'(NS); k++) begin
      a_v = (one << (k * BLK)) - one;
      drive(1'b1, a_v, one, 1'b0);
      tick();
      check_result($sformatf("slice_b%0d", k), one << (k * BLK), 1'b0, 1'b1);
      drive(1'b1, a_v, '0, 1'b1);
      tick();
      check_result($sformatf("slice_c%0d", k), one << (k * BLK), 1'b0, 1'b1);
    end

    // Carry out of the top slice only
    drive(1'b1, one << (W - 1), one << (W - 1), 1'b0);
    tick();
    check_result("top_carry", '0, 1'b1, 1'b1);

    // Back-to-back random operands
    for (int i = 0; i < 32; i++) begin
      a_v = rand_word();
      b_v = rand_word();
      c_v = 1'($urandom_range(0, 1));
      if (i == 5) b_v = ~a_v;
      exp_v = {1'b0, a_v} + {1'b0, b_v} + (W+1)'(c_v);
      drive(1'b1, a_v, b_v, c_v);
      tick();
      check($sformatf("rand%0d", i), {bus.Cout, bus.Sum}, exp_v);
      check($sformatf("rand%0d.valid", i), (W+1)'(bus.out_valid), (W+1)'(1));
    end

    // Reset with in_valid high discards the operand set
    rst_n = 1'b0;
    drive(1'b1, W'(5), W'(7), 1'b1);
    tick();
    check_result("rst_discard", '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, W'(9), W'(9), 1'b0);
    tick();
    check_result("post_rst", '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
